pipeline_ctrl: RTL and testbench

Central hazard and stall controller for the 5-stage RISC-V pipeline (pc, if_id, id_ex, ex_mem, mem_wb).
- Arbitrates stall requests from IF, ID and MEM, and taken-branch redirects from EX.
- Produces per-register hold and bubble controls, a PC redirect, and multi-cycle wrong-path squashing.
- Keeps saturating performance counters for stall cycles and flush events.

---
 rtl/pipeline_ctrl_if.sv | 27 ++
 rtl/pipeline_ctrl.sv | 93 +++++++++
 tb/tb_pipeline_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline stages and the hazard/stall controller.
// The stage side drives requests (master); the controller answers with controls (slave).
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             if_stall_req;
    logic             id_stall_req;
    logic             mem_stall_req;
    logic             ex_branch;
    logic [31:0]      ex_target;
    logic [4:0]       stall;
    logic [4:0]       bubble;
    logic             flush;
    logic [31:0]      new_pc;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output if_stall_req, id_stall_req, mem_stall_req, ex_branch, ex_target,
        input  stall, bubble, flush, new_pc, stall_cycles, flush_events
    );

    modport slave (
        input  if_stall_req, id_stall_req, mem_stall_req, ex_branch, ex_target,
        output stall, bubble, flush, new_pc, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: arbitrates stall/redirect
// requests, drives per-register hold/clear controls and keeps saturating perf counters.
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave ctrl
);
    typedef enum logic {RUN, SQUASH} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       sq_cnt_reg, sq_cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    logic [4:0]  stall_c;
    logic [4:0]  bubble_force;
    logic [4:0]  bubble_derived;
    logic        flush_c;
    logic [31:0] new_pc_c;

    // A register that advances while its upstream neighbour holds must take a bubble.
    assign bubble_derived[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 5; gi++) begin : g_bubble
            assign bubble_derived[gi] = stall_c[gi-1] & ~stall_c[gi];
        end
    endgenerate

    always_comb begin
        stall_c      = 5'b00000;
        bubble_force = 5'b00000;
        flush_c      = 1'b0;
        new_pc_c     = 32'h0;
        state_next   = state_reg;
        sq_cnt_next  = sq_cnt_reg;

        // The front end is on the wrong path for the whole squash window.
        if (state_reg == SQUASH)
            bubble_force[1] = 1'b1;

        if (ctrl.mem_stall_req) begin
            // EX is held, so a pending branch is simply seen again next cycle.
            stall_c = 5'b01111;
        end else if (ctrl.ex_branch) begin
            flush_c         = 1'b1;
            new_pc_c        = ctrl.ex_target;
            bubble_force[1] = 1'b1;
            bubble_force[2] = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_next  = SQUASH;
                sq_cnt_next = 4'(FLUSH_CYCLES - 1);
            end else begin
                state_next  = RUN;
            end
        end else begin
            if (state_reg == SQUASH) begin
                sq_cnt_next = sq_cnt_reg - 4'd1;
                if (sq_cnt_next == 4'd0)
                    state_next = RUN;
            end
            if (ctrl.id_stall_req && state_reg == RUN)
                stall_c = 5'b00011;
            else if (ctrl.if_stall_req)
                stall_c = 5'b00001;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            sq_cnt_reg    <= 4'd0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            sq_cnt_reg <= sq_cnt_next;
            if (stall_c[0] && stall_cnt_reg != {CNT_W{1'b1}})
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (flush_c && flush_cnt_reg != {CNT_W{1'b1}})
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
    end

    // Everything visible is forced quiet for the whole reset cycle.
    assign ctrl.stall        = rst ? 5'b00000 : stall_c;
    assign ctrl.bubble       = rst ? 5'b00000 : (bubble_derived | bubble_force);
    assign ctrl.flush        = rst ? 1'b0 : flush_c;
    assign ctrl.new_pc       = rst ? 32'h0 : new_pc_c;
    assign ctrl.stall_cycles = rst ? '0 : stall_cnt_reg;
    assign ctrl.flush_events = rst ? '0 : flush_cnt_reg;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: instance a (FLUSH_CYCLES=2, 32-bit counters)
// and instance b (FLUSH_CYCLES=4, 4-bit counters) are exercised in turn.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(32)) ia ();
    pipeline_ctrl_if #(.CNT_W(4))  ib ();

    pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut_a (.clk(clk), .rst(rst_a), .ctrl(ia));
    pipeline_ctrl #(.FLUSH_CYCLES(4), .CNT_W(4))  dut_b (.clk(clk), .rst(rst_b), .ctrl(ib));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic drive_a(input logic r, input logic ifs, input logic ids, input logic mems,
                           input logic br, input logic [31:0] tgt);
        rst_a = r; ia.if_stall_req = ifs; ia.id_stall_req = ids;
        ia.mem_stall_req = mems; ia.ex_branch = br; ia.ex_target = tgt;
    endtask

    task automatic drive_b(input logic r, input logic ifs, input logic ids, input logic mems,
                           input logic br, input logic [31:0] tgt);
        rst_b = r; ib.if_stall_req = ifs; ib.id_stall_req = ids;
        ib.mem_stall_req = mems; ib.ex_branch = br; ib.ex_target = tgt;
    endtask

    // Inputs change just after the active edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset with every request high
        drive_a(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        drive_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t1 rst stall", {27'b0, ia.stall}, 32'h0);
        check("t1 rst bubble", {27'b0, ia.bubble}, 32'h0);
        check("t1 rst flush", {31'b0, ia.flush}, 32'h0);
        check("t1 rst new_pc", ia.new_pc, 32'h0);
        next_cycle();
        @(negedge clk);
        check("t1 rst stall_cycles", ia.stall_cycles, 32'h0);
        check("t1 rst flush_events", ia.flush_events, 32'h0);
        next_cycle();
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t1 idle stall", {27'b0, ia.stall}, 32'h0);
        check("t1 idle bubble", {27'b0, ia.bubble}, 32'h0);
        next_cycle();
        @(negedge clk);
        check("t1 idle stall_cycles", ia.stall_cycles, 32'h0);

        // 2: one-cycle load-use stall
        next_cycle();
        drive_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t2 id stall", {27'b0, ia.stall}, 32'h03);
        check("t2 id bubble", {27'b0, ia.bubble}, 32'h04);
        next_cycle();
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t2 stall_cycles", ia.stall_cycles, 32'h1);
        check("t2 released stall", {27'b0, ia.stall}, 32'h0);

        // 3: taken branch, two-cycle squash
        next_cycle();
        drive_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1040);
        @(negedge clk);
        check("t3 flush", {31'b0, ia.flush}, 32'h1);
        check("t3 new_pc", ia.new_pc, 32'h0000_1040);
        check("t3 stall", {27'b0, ia.stall}, 32'h0);
        check("t3 bubble", {27'b0, ia.bubble}, 32'h06);
        next_cycle();
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t3 squash flush", {31'b0, ia.flush}, 32'h0);
        check("t3 squash new_pc", ia.new_pc, 32'h0);
        check("t3 squash bubble", {27'b0, ia.bubble}, 32'h02);
        check("t3 flush_events", ia.flush_events, 32'h1);
        next_cycle();
        @(negedge clk);
        check("t3 back to run bubble", {27'b0, ia.bubble}, 32'h0);

        // 4: mem stall masks a branch for three cycles
        next_cycle();
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t4 mem%0d stall", i), {27'b0, ia.stall}, 32'h0F);
            check($sformatf("t4 mem%0d bubble", i), {27'b0, ia.bubble}, 32'h10);
            check($sformatf("t4 mem%0d flush", i), {31'b0, ia.flush}, 32'h0);
            next_cycle();
        end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2000);
        @(negedge clk);
        check("t4 flush", {31'b0, ia.flush}, 32'h1);
        check("t4 new_pc", ia.new_pc, 32'h0000_2000);
        check("t4 stall_cycles", ia.stall_cycles, 32'h3);
        next_cycle();
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t4 squash bubble", {27'b0, ia.bubble}, 32'h02);
        check("t4 flush_events", ia.flush_events, 32'h1);

        // 5: FLUSH_CYCLES=4 squash stretched by a two-cycle mem stall
        next_cycle();
        drive_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3000);
        @(negedge clk);
        check("t5 flush", {31'b0, ib.flush}, 32'h1);
        check("t5 new_pc", ib.new_pc, 32'h0000_3000);
        next_cycle();
        drive_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t5 sq1 bubble", {27'b0, ib.bubble}, 32'h02);
        next_cycle();
        drive_b(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("t5 mem%0d stall", i), {27'b0, ib.stall}, 32'h0F);
            check($sformatf("t5 mem%0d bubble", i), {27'b0, ib.bubble}, 32'h12);
            next_cycle();
        end
        drive_b(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t5 sq2 id ignored stall", {27'b0, ib.stall}, 32'h0);
        check("t5 sq2 bubble", {27'b0, ib.bubble}, 32'h02);
        next_cycle();
        drive_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t5 sq3 bubble", {27'b0, ib.bubble}, 32'h02);
        next_cycle();
        @(negedge clk);
        check("t5 run bubble", {27'b0, ib.bubble}, 32'h0);
        check("t5 flush_events", {28'b0, ib.flush_events}, 32'h1);
        check("t5 stall_cycles", {28'b0, ib.stall_cycles}, 32'h2);

        // 5b: reset in the middle of a squash
        next_cycle();
        drive_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000);
        next_cycle();
        drive_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive_b(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_5000);
        @(negedge clk);
        check("t5 rst stall", {27'b0, ib.stall}, 32'h0);
        check("t5 rst bubble", {27'b0, ib.bubble}, 32'h0);
        check("t5 rst flush", {31'b0, ib.flush}, 32'h0);
        check("t5 rst new_pc", ib.new_pc, 32'h0);
        check("t5 rst counters", {24'b0, ib.stall_cycles, ib.flush_events}, 32'h0);
        next_cycle();
        drive_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t5 after rst bubble", {27'b0, ib.bubble}, 32'h0);

        // 6: 4-bit stall counter saturates under a long IF stall
        next_cycle();
        drive_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t6 if stall", {27'b0, ib.stall}, 32'h01);
        check("t6 if bubble", {27'b0, ib.bubble}, 32'h02);
        for (int i = 1; i < 20; i++) begin
            next_cycle();
            @(negedge clk);
            if (i == 14)
                check("t6 count 14", {28'b0, ib.stall_cycles}, 32'hE);
        end
        next_cycle();
        drive_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t6 saturated", {28'b0, ib.stall_cycles}, 32'hF);
        next_cycle();
        @(negedge clk);
        check("t6 held", {28'b0, ib.stall_cycles}, 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
